// File: rtl/wordline_pkg.sv
// Shared types and helpers for the word-line decoder.
package wordline_pkg;

  localparam int ADDR_W_DEF = 8;
  // Widest index the decode helper supports; callers cast the result down to their own width.
  localparam int MAX_ADDR_W = 10;
  localparam int MAX_OUT_W  = 1 << MAX_ADDR_W;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    SWEEP = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr);
    logic [MAX_OUT_W-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wordline_skid.sv
// Two-entry valid/ready FIFO used as a skid buffer in front of the decode.
module wordline_skid
  import wordline_pkg::*;
#(
  parameter int W = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic              push, pop;

  // Ready depends only on registered occupancy, so a full buffer stays closed even while popping.
  assign push_ready_o = (occ_q != 2'd2);
  assign pop_valid_o  = (occ_q != 2'd0);
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_valid_o && pop_ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    occ_d = occ_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/wordline_decoder.sv
// Pipelined ADDR_W -> 2**ADDR_W one-hot word-line decoder with skid buffer.
// WORDLINE_INIT_SWEEP_EN adds a post-reset sweep that walks every word line once.
module wordline_decoder
  import wordline_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [ADDR_W-1:0]    in_addr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2**ADDR_W-1:0] out_onehot_o,
  output logic [ADDR_W-1:0]    out_addr_o,
  output logic                 out_init_o,
  output logic                 init_done_o
);

  localparam int OUT_W = 2**ADDR_W;

  state_e            state_q, state_d;
  logic              run;
  logic              skid_in_valid, skid_in_ready;
  logic              skid_out_valid, skid_out_ready;
  logic [ADDR_W-1:0] skid_out_addr;

  assign run            = (state_q == RUN);
  assign skid_in_valid  = in_valid_i && run;
  assign skid_out_ready = out_ready_i && run;

  wordline_skid #(.W(ADDR_W)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (skid_in_valid),
    .push_ready_o (skid_in_ready),
    .push_data_i  (in_addr_i),
    .pop_valid_o  (skid_out_valid),
    .pop_ready_i  (skid_out_ready),
    .pop_data_o   (skid_out_addr)
  );

`ifdef WORDLINE_INIT_SWEEP_EN
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sweep_hs;

  assign sweep_hs = (state_q == SWEEP) && out_ready_i;

  // Wraps to zero on the final handshake, leaving cnt cleared for RUN.
  always_comb begin
    cnt_d = cnt_q;
    if (sweep_hs) cnt_d = cnt_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT: begin
`ifdef WORDLINE_INIT_SWEEP_EN
        state_d = SWEEP;
`else
        state_d = RUN;
`endif
      end
`ifdef WORDLINE_INIT_SWEEP_EN
      SWEEP: if (sweep_hs && (&cnt_q)) state_d = RUN;
`endif
      default: ;
    endcase
  end

  always_comb begin
    out_valid_o = 1'b0;
    out_addr_o  = '0;
    out_init_o  = 1'b0;
    in_ready_o  = 1'b0;
    init_done_o = 1'b0;
    case (state_q)
`ifdef WORDLINE_INIT_SWEEP_EN
      SWEEP: begin
        out_valid_o = 1'b1;
        out_addr_o  = cnt_q;
        out_init_o  = 1'b1;
      end
`endif
      RUN: begin
        out_valid_o = skid_out_valid;
        out_addr_o  = skid_out_valid ? skid_out_addr : '0;
        in_ready_o  = skid_in_ready;
        init_done_o = 1'b1;
      end
      default: ;
    endcase
    out_onehot_o = out_valid_o ? OUT_W'(onehot(MAX_ADDR_W'(out_addr_o))) : '0;
  end

endmodule

// File: tb/tb_wordline_decoder.sv
// Bench for wordline_decoder: ADDR_W=3 and ADDR_W=8 instances, both sweep configurations.
`timescale 1ns/1ps
module tb_wordline_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv3, ordy3, ir3, ov3, oi3, dn3;
  logic [2:0] a3, oa3;
  logic [7:0] oh3;

  logic         iv8, ordy8, ir8, ov8, oi8, dn8;
  logic [7:0]   a8, oa8;
  logic [255:0] oh8;

  wordline_decoder #(.ADDR_W(3)) u3 (
    .clk(clk), .rst(rst), .in_valid_i(iv3), .in_ready_o(ir3), .in_addr_i(a3),
    .out_valid_o(ov3), .out_ready_i(ordy3), .out_onehot_o(oh3), .out_addr_o(oa3),
    .out_init_o(oi3), .init_done_o(dn3)
  );

  wordline_decoder #(.ADDR_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid_i(iv8), .in_ready_o(ir8), .in_addr_i(a8),
    .out_valid_o(ov8), .out_ready_i(ordy8), .out_onehot_o(oh8), .out_addr_o(oa8),
    .out_init_o(oi8), .init_done_o(dn8)
  );

  typedef struct {
    logic       iv;
    logic [2:0] a;
    logic       ordy;
    logic       ev;
    logic [7:0] eoh;
    logic [2:0] ea;
    logic       ei;
    logic       er;
    logic       ed;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   errors  = 0;

`ifdef WORDLINE_INIT_SWEEP_EN
  localparam int DONE_CYC8 = 257;
`else
  localparam int DONE_CYC8 = 1;
`endif

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk3(input string t, input logic ev, input logic [7:0] eoh, input logic [2:0] ea,
                      input logic ei, input logic er, input logic ed);
    chk({t, ".valid"},  256'(ov3), 256'(ev));
    chk({t, ".onehot"}, 256'(oh3), 256'(eoh));
    chk({t, ".addr"},   256'(oa3), 256'(ea));
    chk({t, ".init"},   256'(oi3), 256'(ei));
    chk({t, ".ready"},  256'(ir3), 256'(er));
    chk({t, ".done"},   256'(dn3), 256'(ed));
  endtask

  task automatic add(input logic iv, input logic [2:0] a, input logic ordy, input logic ev,
                     input logic [7:0] eoh, input logic [2:0] ea, input logic ei,
                     input logic er, input logic ed);
    vec_t v;
    v.iv = iv; v.a = a; v.ordy = ordy; v.ev = ev; v.eoh = eoh;
    v.ea = ea; v.ei = ei; v.er = er; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int q[$];
    int c;
    logic acc, pop;

    iv3 = 0; a3 = 0; ordy3 = 1;
    iv8 = 0; a8 = 0; ordy8 = 1;

    // Vectors start in the WAIT cycle right after reset release.
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
`ifdef WORDLINE_INIT_SWEEP_EN
    for (int k = 0; k < 8; k++) add(0, 0, 1, 1, 8'(1 << k), 3'(k), 1, 0, 0);
`endif
    add(1, 0, 1, 0, 8'h00, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'h01, 0, 0, 1, 1);
    add(1, 1, 0, 0, 8'h00, 0, 0, 1, 1);
    add(1, 2, 0, 1, 8'h02, 1, 0, 1, 1);
    add(1, 3, 0, 1, 8'h02, 1, 0, 0, 1);
    add(1, 3, 1, 1, 8'h02, 1, 0, 0, 1);
    add(1, 3, 1, 1, 8'h04, 2, 0, 1, 1);
    add(0, 0, 1, 1, 8'h08, 3, 0, 1, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 1, 1);

    @(negedge clk);
    @(negedge clk);
    chk3("rst3", 0, 8'h00, 0, 0, 0, 0);
    chk("rst8.valid",  256'(ov8), 256'(0));
    chk("rst8.onehot", oh8, 256'(0));
    chk("rst8.ready",  256'(ir8), 256'(0));
    chk("rst8.done",   256'(dn8), 256'(0));
    rst = 1'b0;

    foreach (tbl[i]) begin
      chk3($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].eoh, tbl[i].ea, tbl[i].ei,
           tbl[i].er, tbl[i].ed);
      iv3 = tbl[i].iv; a3 = tbl[i].a; ordy3 = tbl[i].ordy;
      @(negedge clk);
    end
    iv3 = 0; ordy3 = 1;

    // ADDR_W=8: sweep walk and init latency, then random traffic against a queue model.
    pulse_reset();
    c = 0;
    while (!dn8 && c < 600) begin
`ifdef WORDLINE_INIT_SWEEP_EN
      if (c >= 1) begin
        chk("sweep8.onehot", oh8, 256'(1) << (c - 1));
        chk("sweep8.init", 256'(oi8), 256'(1));
      end
`else
      chk("nosweep8.init", 256'(oi8), 256'(0));
`endif
      @(negedge clk);
      c++;
    end
    chk("init8.cycles", 256'(c), 256'(DONE_CYC8));

    for (int i = 0; i < 400; i++) begin
      chk("rand.valid", 256'(ov8), 256'(q.size() > 0));
      chk("rand.ready", 256'(ir8), 256'(q.size() < 2));
      chk("rand.init",  256'(oi8), 256'(0));
      chk("rand.done",  256'(dn8), 256'(1));
      if (q.size() > 0) begin
        chk("rand.onehot", oh8, 256'(1) << q[0]);
        chk("rand.addr", 256'(oa8), 256'(q[0]));
      end else begin
        chk("rand.onehot_idle", oh8, 256'(0));
      end
      iv8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom);
      ordy8 = ($urandom_range(0, 3) != 0);
      if (i == 0) begin iv8 = 1; a8 = 8'd5;   ordy8 = 1; end
      if (i == 1) begin iv8 = 1; a8 = 8'd130; ordy8 = 1; end
      acc = iv8 && (q.size() < 2);
      pop = (q.size() > 0) && ordy8;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(int'(a8));
      @(negedge clk);
    end
    iv8 = 0; ordy8 = 1;

`ifdef WORDLINE_INIT_SWEEP_EN
    // Reset in the middle of the sweep restarts it from word line 0.
    pulse_reset();
    chk3("midsweep.wait", 0, 8'h00, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("midsweep.cnt4", 256'(oh3), 256'(8'h10));
    rst = 1'b1;
    #1;
    chk3("midsweep.rst", 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk3("midsweep.wait2", 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    chk3("midsweep.restart", 1, 8'h01, 0, 1, 0, 0);
`endif

    // Reset with two requests buffered drops them.
    pulse_reset();
    c = 0;
    while (!dn3 && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("full.init3", 256'(dn3), 256'(1));
    iv3 = 1; a3 = 3'd1; ordy3 = 0;
    @(negedge clk);
    a3 = 3'd2;
    @(negedge clk);
    iv3 = 0;
    chk3("full.buffered", 1, 8'h02, 1, 0, 0, 1);
    rst = 1'b1;
    #1;
    chk3("full.rst", 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk3("full.wait", 0, 8'h00, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
`ifdef WORDLINE_INIT_SWEEP_EN
      chk3($sformatf("full.after[%0d]", i), 1, 8'h01, 0, 1, 0, 0);
`else
      chk3($sformatf("full.after[%0d]", i), 0, 8'h00, 0, 0, 1, 1);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
